// File: rtl/alu_seq.sv
// Multi-cycle ALU: logic/arithmetic ops complete in one cycle. Shifts move one
// bit per cycle through a shift register, so latency equals the shift amount.
module alu_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              illegal
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [SH_W-1:0]   count_p0;
  logic [DATA_W-1:0] sreg_p0;
  logic [3:0]        op_p0;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] shift_next;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_SRA;
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // Shift codes only reach this path with a zero shift amount, so they pass a through.
  function automatic logic [DATA_W-1:0] alu_op(input logic [3:0] op,
                                               input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
    logic signed [DATA_W-1:0] xs;
    logic signed [DATA_W-1:0] ys;
    xs = x;
    ys = y;
    case (op)
      OP_AND:                 return x & y;
      OP_OR:                  return x | y;
      OP_ADD:                 return x + y;
      OP_XOR:                 return x ^ y;
      OP_SUB:                 return x - y;
      OP_SLT:                 return {{(DATA_W-1){1'b0}}, (xs < ys)};
      OP_SLL, OP_SRL, OP_SRA: return x;
      default:                return '0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] shift_step(input logic [3:0] op,
                                                   input logic [DATA_W-1:0] v);
    case (op)
      OP_SLL:  return {v[DATA_W-2:0], 1'b0};
      OP_SRL:  return {1'b0, v[DATA_W-1:1]};
      default: return {v[DATA_W-1], v[DATA_W-1:1]};
    endcase
  endfunction

  assign shamt      = b[SH_W-1:0];
  assign shift_next = shift_step(op_p0, sreg_p0);
  assign ready      = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count_p0 <= '0;
      sreg_p0  <= '0;
      op_p0    <= '0;
      result   <= '0;
      zero     <= 1'b1;
      illegal  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_shift(alu_control) && (shamt != '0)) begin
              sreg_p0  <= a;
              count_p0 <= shamt;
              op_p0    <= alu_control;
              state    <= SHIFT;
            end else begin
              result  <= alu_op(alu_control, a, b);
              zero    <= (alu_op(alu_control, a, b) == '0);
              illegal <= ~is_legal(alu_control);
              done    <= 1'b1;
            end
          end
        end
        SHIFT: begin
          sreg_p0  <= shift_next;
          count_p0 <= count_p0 - 1'b1;
          if (count_p0 == 1) begin
            result  <= shift_next;
            zero    <= (shift_next == '0);
            illegal <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors push expected completions,
// a monitor pops and compares whenever done is seen.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  alu_control;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          due;
  } exp_t;

  exp_t sb[$];

  alu_seq dut (
    .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
    .a(a), .b(b), .ready(ready), .done(done), .result(result),
    .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done result=%h zero=%0b illegal=%0b required no completion",
                 result, zero, illegal);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.res || zero !== e.z || illegal !== e.ill || cyc != e.due) begin
          errors++;
          $display("FAIL %s got result=%h zero=%0b illegal=%0b cyc=%0d required result=%h zero=%0b illegal=%0b cyc=%0d",
                   e.name, result, zero, illegal, cyc, e.res, e.z, e.ill, e.due);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] er, input logic ez,
                       input logic eil, input int lat, input bit push);
    int w;
    w = 0;
    while (!ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout got ready=%0b required=1", name, ready);
    end
    alu_control = op;
    a = av;
    b = bv;
    start = 1'b1;
    if (push) sb.push_back('{name, er, ez, eil, cyc + lat});
    @(negedge clk);
    start = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h0BAD_F00D;
    alu_control = 4'h3;
  endtask

  initial begin
    int w;
    rst = 1'b1;
    start = 1'b0;
    alu_control = 4'h0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_result", result, 32'h0);
    chk("rst_zero", {31'b0, zero}, 32'h1);
    chk("rst_illegal", {31'b0, illegal}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    rst = 1'b0;
    chk("rst_ready", {31'b0, ready}, 32'h1);

    issue("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1, 1);
    issue("sub_zero", 4'b0110, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1, 1);
    issue("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1, 1);
    issue("slt_false", 4'b0111, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1, 1);
    issue("and", 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1, 1);
    issue("or", 4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0, 1, 1);
    issue("xor", 4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1'b0, 1, 1);

    issue("sra4", 4'b1000, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, 1'b0, 5, 1);
    for (int i = 0; i < 4; i++) begin
      chk("sra_busy_ready", {31'b0, ready}, 32'h0);
      alu_control = 4'b0010;
      a = 32'h1;
      b = 32'h1;
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;

    issue("srl1", 4'b0101, 32'h8000_0000, 32'h1, 32'h4000_0000, 1'b0, 1'b0, 2, 1);
    issue("sll_hibits", 4'b0100, 32'h3, 32'h25, 32'h60, 1'b0, 1'b0, 6, 1);
    issue("sll31", 4'b0100, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 32, 1);
    issue("b2b_add", 4'b0010, 32'h2, 32'h3, 32'h5, 1'b0, 1'b0, 1, 1);
    issue("illegal_f", 4'b1111, 32'h1234, 32'h1, 32'h0, 1'b1, 1'b1, 1, 1);
    issue("srl_shamt0", 4'b0101, 32'h1234, 32'h0, 32'h1234, 1'b0, 1'b0, 1, 1);
    issue("illegal_9", 4'b1001, 32'h7, 32'h7, 32'h0, 1'b1, 1'b1, 1, 1);
    issue("sll_shamt0", 4'b0100, 32'hABCD_0000, 32'h20, 32'hABCD_0000, 1'b0, 1'b0, 1, 1);

    issue("sll20_abort", 4'b0100, 32'h1, 32'd20, 32'h0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_result", result, 32'h0);
    chk("abort_zero", {31'b0, zero}, 32'h1);
    chk("abort_ready", {31'b0, ready}, 32'h1);
    repeat (25) @(negedge clk);
    issue("add_after_rst", 4'b0010, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1, 1);

    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only when ready=1
- alu_control  input  4  operation code from the ALU control decoder
- a  input  32  operand A
- b  input  32  operand B; b[4:0] is the shift amount for shifts
- ready  output  1  block can accept start this cycle
- done  output  1  one-cycle pulse; result/zero/illegal valid
- result  output  32  operation result, held until next completion
- zero  output  1  result == 0, registered with result
- illegal  output  1  completed operation had an undefined code

Function
REQ-002 Operation codes SHALL be:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0011 XOR
- 0100 SLL
- 0101 SRL
- 1000 SRA
- 0110 SUB
- 0111 SLT (signed, result 0 or 1)
- all other codes, including 1111, illegal
REQ-003 ADD/SUB SHALL be modulo 2^32 with no carry or overflow output.
REQ-004 The FSM SHALL have two states: IDLE and SHIFT.
REQ-005 ready SHALL be 1 exactly when state=IDLE; it is combinational from state only.
REQ-006 start=1 at an edge in IDLE SHALL accept the request and latch a, b[4:0] and alu_control.
REQ-007 start SHALL be ignored in SHIFT; inputs may change freely while busy.
REQ-008 Single-cycle path, taken for non-shift codes, illegal codes, and shifts with b[4:0]=0:
- result, zero, illegal are written at the accepting edge
- done=1 for the following cycle
- state stays IDLE
REQ-009 An illegal code SHALL complete on the single-cycle path with result=0, zero=1, illegal=1.
REQ-010 A shift with b[4:0]=0 SHALL return a unchanged, with illegal=0.
REQ-011 Shift with shamt=b[4:0]>=1 at accepting edge k:
- at edge k, load the shift register with a and count with shamt; enter SHIFT
- at each edge in SHIFT, shift the register by one bit and decrement count
- SLL fills with 0, SRL fills with 0, SRA replicates bit 31
REQ-012 At the SHIFT edge where count=1, the block SHALL:
- write the shifted value to result and update zero
- clear illegal
- return to IDLE
- assert done the following cycle
This gives done visible after edge k+shamt (latency shamt cycles, max 31).
REQ-013 done SHALL be a one-cycle pulse.
REQ-014 A start accepted in the same cycle that done=1 (back-to-back) SHALL be honoured; done is then high for consecutive cycles, once per operation.
REQ-015 result, zero and illegal SHALL change only at completion edges or on reset.
REQ-016 zero SHALL be set from the final 32-bit result, never from intermediate shift values.

Reset
REQ-017 rst=1 at any edge SHALL force the following, overriding start:
- state=IDLE, count=0, shift register=0
- result=0, zero=1, illegal=0, done=0
REQ-018 Reset during SHIFT SHALL abort the operation with no done pulse.
REQ-019 After rst is released, ready=1 in the next cycle and start is accepted.

Verification
REQ-020 ADD: a=0x7FFFFFFF, b=1, code 0010 -> one cycle later done=1, result=0x80000000, zero=0.
REQ-021 SUB and SLT:
- a=5, b=5, code 0110 -> result=0, zero=1
- a=0xFFFFFFFF, b=1, code 0111 -> result=1
REQ-022 SRA: a=0x80000000, b=4, code 1000 -> ready=0 for 4 cycles; done after edge k+4; result=0xF8000000; starts issued while busy are ignored.
REQ-023 Back-to-back: SLL a=1, b=31 followed by ADD a=2, b=3 issued in the done cycle -> result 0x80000000, then result 5 one cycle later; two separate done pulses.
REQ-024 Illegal and shamt-0 cases:
- code 1111 -> result=0, zero=1, illegal=1
- following SRL a=0x1234, b=0 -> result=0x1234, illegal=0, latency 1
REQ-025 Reset mid-operation: rst pulsed 3 cycles into SLL b=20 -> no done; result=0, zero=1; ready=1 after release; a new ADD completes normally.
